// File: rtl/ebox_pkg.sv
// ---------------------------------------------------------------------------
// ebox_pkg -- shared EBOX definitions.
//
// Contents used by the IR dispatch RAM controller:
//   DRAM_ADDR_BITS / DRAM_WIDTH  geometry of the 512 x 15 dispatch RAM
//   irDramCtlState_t             controller state encoding
//   DIAG_*                       EBUS diag sub-function codes
//   wr_count_inc()               saturating increment for the 10-bit write count
// ---------------------------------------------------------------------------
package ebox_pkg;

   localparam int unsigned DRAM_ADDR_BITS = 9;
   localparam int unsigned DRAM_WIDTH     = 15;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      RB,
      CMP,
      DONE,
      SWEEP
   } irDramCtlState_t;

   // Diag sub-function codes carried on diag_func.
   localparam logic [2:0] DIAG_ADDR_HI  = 3'd0;  // addr[0:2]   <= data[3:5]
   localparam logic [2:0] DIAG_ADDR_LO  = 3'd1;  // addr[3:8]   <= data[0:5]
   localparam logic [2:0] DIAG_WD_HI    = 3'd2;  // wdata[0:5]  <= data[0:5]
   localparam logic [2:0] DIAG_WD_MID   = 3'd3;  // wdata[6:11] <= data[0:5]
   localparam logic [2:0] DIAG_WD_LO_WR = 3'd4;  // wdata[12:14] <= data[3:5], start write
   localparam logic [2:0] DIAG_SWEEP    = 3'd5;  // zero-fill the whole RAM
   localparam logic [2:0] DIAG_CLR_ERR  = 3'd6;  // clear sticky wr_err
   localparam logic [2:0] DIAG_NOP      = 3'd7;

   // Write counter holds at all-ones rather than wrapping.
   function automatic logic [9:0] wr_count_inc(input logic [9:0] count);
      return (count == 10'h3FF) ? count : count + 10'd1;
   endfunction

endpackage

// File: rtl/ir_dram_ctl.sv
// ---------------------------------------------------------------------------
// ir_dram_ctl -- owner of the single port of the IR dispatch RAM (DRAM).
//
// EBOX dispatch reads (load_dram) always win the port; diag writes and the
// zero-fill sweep stall in place while a dispatch read is present and resume
// on the next free cycle.  A diag write is assembled from EBUS diag
// functions, written, optionally read back and compared, and then the
// address register advances so consecutive words can be loaded quickly.
//
// Ports:
//   clk              IR clock, all logic on posedge
//   CROBAR           synchronous active-high reset
//   load_dram        dispatch read request (one-cycle pulse)
//   read_addr        dispatch read address
//   diag_func_valid  strobe for diag_func / diag_data
//   diag_func        diag sub-function code
//   diag_data        EBUS diag data
//   dram_addr        RAM address (combinational)
//   dram_we          RAM write enable (combinational)
//   dram_din         RAM write data
//   dram_dout        RAM read data, valid the cycle after its address
//   busy             write or sweep in progress (registered)
//   wr_err           sticky readback mismatch
//   wr_count         writes completed since reset / sweep start (saturating)
// ---------------------------------------------------------------------------
module ir_dram_ctl
   import ebox_pkg::*;
#(
   parameter int ADDR_BITS  = DRAM_ADDR_BITS,
   parameter int DATA_WIDTH = DRAM_WIDTH,
   parameter int VERIFY     = 1
) (
   input  logic                  clk,
   input  logic                  CROBAR,
   input  logic                  load_dram,
   input  logic [0:ADDR_BITS-1]  read_addr,
   input  logic                  diag_func_valid,
   input  logic [0:2]            diag_func,
   input  logic [0:5]            diag_data,
   output logic [0:ADDR_BITS-1]  dram_addr,
   output logic                  dram_we,
   output logic [0:DATA_WIDTH-1] dram_din,
   input  logic [0:DATA_WIDTH-1] dram_dout,
   output logic                  busy,
   output logic                  wr_err,
   output logic [0:9]            wr_count
);

   irDramCtlState_t        state;
   logic [0:ADDR_BITS-1]   addr;
   logic [0:DATA_WIDTH-1]  wdata;

   // Port mux.  A dispatch read takes the port outright; the FSM sees
   // load_dram too and simply holds its state for that cycle.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
      dram_addr = addr;
      dram_we   = 1'b0;
      dram_din  = wdata;
      if (state == SWEEP) dram_din = '0;
      if (load_dram) dram_addr = read_addr;
      else           dram_we   = (state == WRITE) || (state == SWEEP);
   end

   // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
   always_ff @(posedge clk) begin
      if (CROBAR) begin
         state    <= IDLE;
         addr     <= '0;
         wdata    <= '0;
         wr_count <= '0;
         busy     <= 1'b0;
         wr_err   <= 1'b0;
      end else begin
         // Clear is honoured in any state; a mismatch set later in this
         // block overrides it because the last assignment wins.
         if (diag_func_valid && diag_func == DIAG_CLR_ERR) wr_err <= 1'b0;

         case (state)
            // busy is low only in IDLE, so functions 0-5 are naturally
            // ignored everywhere else.
            IDLE: begin
               if (diag_func_valid) begin
                  case (diag_func)
                     DIAG_ADDR_HI:  addr[0:2]    <= diag_data[3:5];
                     DIAG_ADDR_LO:  addr[3:8]    <= diag_data[0:5];
                     DIAG_WD_HI:    wdata[0:5]   <= diag_data;
                     DIAG_WD_MID:   wdata[6:11]  <= diag_data;
                     DIAG_WD_LO_WR: begin
                        wdata[12:14] <= diag_data[3:5];
                        state        <= WRITE;
                        busy         <= 1'b1;
                     end
                     DIAG_SWEEP: begin
                        addr     <= '0;
                        wr_count <= '0;
                        state    <= SWEEP;
                        busy     <= 1'b1;
                     end
                     default: ;
                  endcase
               end
            end

            WRITE: begin
               if (!load_dram) begin
                  wr_count <= wr_count_inc(wr_count);
                  state    <= (VERIFY != 0) ? RB : DONE;
               end
            end

            RB: if (!load_dram) state <= CMP;

            // Read data belongs to the RB address; a dispatch read issued
            // now only affects next cycle's dram_dout.
            CMP: begin
               if (dram_dout != wdata) wr_err <= 1'b1;
               state <= DONE;
            end

            DONE: begin
               addr  <= addr + 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end

            SWEEP: begin
               if (!load_dram) begin
                  addr     <= addr + 1'b1;
                  wr_count <= wr_count_inc(wr_count);
                  if (addr == '1) begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ir_dram_ctl.sv
// ---------------------------------------------------------------------------
// tb_ir_dram_ctl -- directed bench for the IR dispatch RAM controller.
// Inputs change 1 ns after posedge; outputs are sampled on negedge.  A
// behavioural 512 x 15 synchronous RAM answers the DUT, and every write
// pulse seen at a posedge is logged for the sequence checks.
// ---------------------------------------------------------------------------
module tb_ir_dram_ctl;

   logic        clk = 1'b0;
   logic        CROBAR;
   logic        load_dram;
   logic [0:8]  read_addr;
   logic        diag_func_valid;
   logic [0:2]  diag_func;
   logic [0:5]  diag_data;
   logic [0:8]  dram_addr;
   logic        dram_we;
   logic [0:14] dram_din;
   logic [0:14] dram_dout;
   logic        busy;
   logic        wr_err;
   logic [0:9]  wr_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ir_dram_ctl dut (
      .clk             (clk),
      .CROBAR          (CROBAR),
      .load_dram       (load_dram),
      .read_addr       (read_addr),
      .diag_func_valid (diag_func_valid),
      .diag_func       (diag_func),
      .diag_data       (diag_data),
      .dram_addr       (dram_addr),
      .dram_we         (dram_we),
      .dram_din        (dram_din),
      .dram_dout       (dram_dout),
      .busy            (busy),
      .wr_err          (wr_err),
      .wr_count        (wr_count)
   );

   // RAM model with a hook that forces read data to zero.
   logic [0:14] mem [0:511];
   logic [0:14] ram_q;
   logic        force_zero = 1'b0;

   always @(posedge clk) begin
      if (dram_we) mem[dram_addr] <= dram_din;
      ram_q <= mem[dram_addr];
   end
   assign dram_dout = force_zero ? 15'd0 : ram_q;

   // Write log and busy-cycle counter.
   typedef struct { logic [8:0] a; logic [14:0] d; } wr_t;
   wr_t wlog[$];
   int  busy_cycles = 0;

   always @(posedge clk) begin
      if (dram_we) wlog.push_back('{a: dram_addr, d: dram_din});
      if (busy) busy_cycles++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic ld, input logic [8:0] ra, input logic v,
                        input logic [2:0] f, input logic [5:0] d);
      load_dram       = ld;
      read_addr       = ra;
      diag_func_valid = v;
      diag_func       = f;
      diag_data       = d;
   endtask

   task automatic diag(input logic [2:0] f, input logic [5:0] d);
      drive(1'b0, 9'd0, 1'b1, f, d);
      step();
      drive(1'b0, 9'd0, 1'b0, 3'd0, 6'd0);
   endtask

   task automatic wait_not_busy(input string name, input int max_cycles);
      int n = 0;
      while (busy && n < max_cycles) begin
         step();
         n++;
      end
      if (n >= max_cycles) check({name, "_timeout"}, 32'(busy), 32'd0);
   endtask

   // Per-cycle vector: inputs for the cycle and outputs expected at its negedge.
   typedef struct {
      logic        ld;
      logic [8:0]  ra;
      logic        v;
      logic [2:0]  f;
      logic [5:0]  d;
      logic        we;
      logic [8:0]  addr;
      logic [14:0] din;
      logic        busy;
      logic        err;
      logic [9:0]  cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic ld, input logic [8:0] ra, input logic v,
                               input logic [2:0] f, input logic [5:0] d,
                               input logic we, input logic [8:0] addr, input logic [14:0] din,
                               input logic bsy, input logic [9:0] cnt);
      vecs.push_back('{ld: ld, ra: ra, v: v, f: f, d: d, we: we, addr: addr,
                       din: din, busy: bsy, err: 1'b0, cnt: cnt});
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int sz;
      int bad;

      // Write path: addr 0o112, data 0o77005, verified write.
      add(0, 0,      1, 3'd0, 6'o01, 0, 9'o000, 0,       0, 0);
      add(0, 0,      1, 3'd1, 6'o12, 0, 9'o100, 0,       0, 0);
      add(0, 0,      1, 3'd2, 6'o77, 0, 9'o112, 0,       0, 0);
      add(0, 0,      1, 3'd3, 6'o00, 0, 9'o112, 0,       0, 0);
      add(0, 0,      1, 3'd4, 6'o05, 0, 9'o112, 0,       0, 0);
      add(0, 0,      0, 3'd0, 6'o00, 1, 9'o112, 15'o77005, 1, 0);  // WRITE
      add(0, 0,      0, 3'd0, 6'o00, 0, 9'o112, 0,       1, 1);  // RB
      add(0, 0,      0, 3'd0, 6'o00, 0, 9'o112, 0,       1, 1);  // CMP
      add(0, 0,      0, 3'd0, 6'o00, 0, 9'o112, 0,       1, 1);  // DONE
      add(0, 0,      0, 3'd0, 6'o00, 0, 9'o113, 0,       0, 1);  // IDLE
      // Preemption: dispatch reads hold WRITE for three cycles, one hits CMP.
      add(0, 0,      1, 3'd4, 6'o02, 0, 9'o113, 0,       0, 1);
      add(1, 9'o400, 0, 3'd0, 6'o00, 0, 9'o400, 0,       1, 1);
      add(1, 9'o400, 0, 3'd0, 6'o00, 0, 9'o400, 0,       1, 1);
      add(1, 9'o400, 0, 3'd0, 6'o00, 0, 9'o400, 0,       1, 1);
      add(0, 0,      0, 3'd0, 6'o00, 1, 9'o113, 15'o77002, 1, 1);  // WRITE resumes
      add(0, 0,      0, 3'd0, 6'o00, 0, 9'o113, 0,       1, 2);  // RB
      add(1, 9'o400, 0, 3'd0, 6'o00, 0, 9'o400, 0,       1, 2);  // CMP + dispatch read
      add(0, 0,      0, 3'd0, 6'o00, 0, 9'o113, 0,       1, 2);  // DONE
      add(0, 0,      0, 3'd0, 6'o00, 0, 9'o114, 0,       0, 2);  // IDLE

      // Reset.
      CROBAR = 1'b1;
      drive(1'b0, 9'd0, 1'b0, 3'd0, 6'd0);
      step();
      step();
      CROBAR = 1'b0;
      check("rst_busy",  32'(busy),      32'd0);
      check("rst_err",   32'(wr_err),    32'd0);
      check("rst_count", 32'(wr_count),  32'd0);
      check("rst_we",    32'(dram_we),   32'd0);
      check("rst_addr",  32'(dram_addr), 32'd0);

      // Table-driven write path and preemption.
      foreach (vecs[i]) begin
         drive(vecs[i].ld, vecs[i].ra, vecs[i].v, vecs[i].f, vecs[i].d);
         @(negedge clk);
         check($sformatf("vec%0d_we", i),   32'(dram_we),   32'(vecs[i].we));
         check($sformatf("vec%0d_addr", i), 32'(dram_addr), 32'(vecs[i].addr));
         if (vecs[i].we)
            check($sformatf("vec%0d_din", i), 32'(dram_din), 32'(vecs[i].din));
         check($sformatf("vec%0d_busy", i), 32'(busy),      32'(vecs[i].busy));
         check($sformatf("vec%0d_err", i),  32'(wr_err),    32'(vecs[i].err));
         check($sformatf("vec%0d_cnt", i),  32'(wr_count),  32'(vecs[i].cnt));
         step();
      end
      drive(1'b0, 9'd0, 1'b0, 3'd0, 6'd0);
      check("mem_112", 32'(mem[9'o112]), 32'o77005);
      check("mem_113", 32'(mem[9'o113]), 32'o77002);

      // Mismatch: write 1 at 0o114, readback forced to 0, clear strobed in CMP.
      diag(3'd2, 6'o00);
      diag(3'd3, 6'o00);
      force_zero = 1'b1;
      diag(3'd4, 6'o01);                               // now in WRITE
      step();                                          // RB
      step();                                          // CMP
      drive(1'b0, 9'd0, 1'b1, 3'd6, 6'd0);
      step();
      drive(1'b0, 9'd0, 1'b0, 3'd0, 6'd0);
      wait_not_busy("mm", 10);
      force_zero = 1'b0;
      check("mm_err_set_wins", 32'(wr_err),   32'd1);
      check("mm_count",        32'(wr_count), 32'd3);
      diag(3'd4, 6'o01);
      wait_not_busy("good", 10);
      check("mm_err_sticky",   32'(wr_err),   32'd1);
      check("good_count",      32'(wr_count), 32'd4);
      check("good_addr",       32'(dram_addr), 32'o116);
      diag(3'd6, 6'd0);
      check("err_cleared",     32'(wr_err),   32'd0);

      // Wrap: write at 511, address returns to 0.
      diag(3'd0, 6'o07);
      diag(3'd1, 6'o77);
      wlog.delete();
      diag(3'd4, 6'o03);
      wait_not_busy("wrap", 10);
      check("wrap_writes", 32'(wlog.size()), 32'd1);
      if (wlog.size() > 0) check("wrap_wr_addr", 32'(wlog[0].a), 32'd511);
      check("wrap_addr",   32'(dram_addr), 32'd0);
      check("wrap_count",  32'(wr_count),  32'd5);

      // Sweep with a function 4 strobed part way through.
      wlog.delete();
      busy_cycles = 0;
      diag(3'd5, 6'd0);
      repeat (200) step();
      diag(3'd4, 6'o07);
      wait_not_busy("sweep", 1000);
      check("sweep_writes", 32'(wlog.size()),  32'd512);
      bad = 0;
      foreach (wlog[i]) if (wlog[i].a != 9'(i) || wlog[i].d != 15'd0) bad++;
      check("sweep_seq",    32'(bad),          32'd0);
      check("sweep_busy",   32'(busy_cycles),  32'd512);
      check("sweep_count",  32'(wr_count),     32'd512);
      check("sweep_addr",   32'(dram_addr),    32'd0);
      repeat (5) step();
      check("sweep_no_late_write", 32'(wlog.size()), 32'd512);
      check("sweep_idle_busy",     32'(busy),        32'd0);

      // Reset in the cycle of sweep write #100.
      wlog.delete();
      diag(3'd5, 6'd0);                                // now in write #1
      repeat (99) step();                              // now in write #100
      @(negedge clk);
      check("rs_we_100",   32'(dram_we),   32'd1);
      check("rs_addr_100", 32'(dram_addr), 32'd99);
      CROBAR = 1'b1;
      step();
      CROBAR = 1'b0;
      @(negedge clk);
      check("rs_we",    32'(dram_we),  32'd0);
      check("rs_busy",  32'(busy),     32'd0);
      check("rs_count", 32'(wr_count), 32'd0);
      check("rs_addr",  32'(dram_addr), 32'd0);
      sz = wlog.size();
      repeat (4) step();
      check("rs_no_write", 32'(wlog.size()), 32'(sz));

      // Normal write after reset: addr 0, data 0o12003.
      wlog.delete();
      diag(3'd2, 6'o12);
      diag(3'd4, 6'o03);
      wait_not_busy("post_rs", 10);
      check("post_rs_writes", 32'(wlog.size()), 32'd1);
      if (wlog.size() > 0) begin
         check("post_rs_wr_addr", 32'(wlog[0].a), 32'd0);
         check("post_rs_wr_din",  32'(wlog[0].d), 32'o12003);
      end
      check("post_rs_err",   32'(wr_err),    32'd0);
      check("post_rs_count", 32'(wr_count),  32'd1);
      check("post_rs_addr",  32'(dram_addr), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
